// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC streamer: takes codes from an AXI-Stream slave and shifts them
// onto a shared sclk/mosi bus. Each channel has its own chip select; ldac_n is shared.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a beat; s_axis_ready follows en
// S_SETUP | cs_n[dest] low and mosi = MSB, sclk held low
// S_SHIFT | SCLK_DIV low / SCLK_DIV high per bit, MSB first
// S_HOLD  | cs_n still low after the last sclk fall
// S_GAP   | one cycle with every cs_n high
// S_LDAC  | ldac_n low for LDAC_CYC cycles
module dac_spi_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int SCLK_DIV   = 2,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int LDAC_CYC   = 2,
    parameter int LDAC_MODE  = 0,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic [CH_W-1:0]       s_axis_dest,
    input  logic                  s_axis_last,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CH-1:0]     cs_n,
    output logic                  ldac_n,
    output logic                  busy,
    output logic                  dest_err
);

    localparam int MAX_A   = (SCLK_DIV > CS_SETUP) ? SCLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > LDAC_CYC) ? CS_HOLD : LDAC_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] sh;
    logic                  last_q;

    logic                  dest_ok;
    logic [CH_W-1:0]       dest_eff;
    logic [NUM_CH-1:0]     sel_mask;
    logic                  handshake;
    logic                  unused_dest;

    // With a single channel the dest field carries no information.
    assign unused_dest = ^s_axis_dest;

    always_comb begin
        dest_ok  = 1'b1;
        dest_eff = '0;
        if (NUM_CH > 1) begin
            dest_eff = s_axis_dest;
            dest_ok  = ({1'b0, s_axis_dest} < (CH_W + 1)'(NUM_CH));
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_mask[i] = (dest_eff == CH_W'(i));
        end
    end

    assign handshake = s_axis_valid & s_axis_ready;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            last_q       <= 1'b0;
            s_axis_ready <= 1'b0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            cs_n         <= '1;
            ldac_n       <= 1'b1;
            busy         <= 1'b0;
            dest_err     <= 1'b0;
        end else begin
            dest_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk   <= 1'b0;
                    mosi   <= 1'b0;
                    cs_n   <= '1;
                    ldac_n <= 1'b1;
                    busy   <= 1'b0;
                    s_axis_ready <= en;
                    if (handshake) begin
                        if (dest_ok) begin
                            state        <= S_SETUP;
                            sh           <= s_axis_data;
                            last_q       <= s_axis_last;
                            cs_n         <= ~sel_mask;
                            mosi         <= s_axis_data[DATA_WIDTH-1];
                            busy         <= 1'b1;
                            s_axis_ready <= 1'b0;
                            cnt          <= CNT_W'(CS_SETUP - 1);
                        end else begin
                            // Bad address: swallow the beat, flag it, stay ready.
                            dest_err <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state   <= S_SHIFT;
                        cnt     <= CNT_W'(SCLK_DIV - 1);
                        bit_cnt <= BIT_W'(DATA_WIDTH - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sclk) begin
                        sclk <= 1'b1;
                        cnt  <= CNT_W'(SCLK_DIV - 1);
                    end else begin
                        sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= S_HOLD;
                            cnt   <= CNT_W'(CS_HOLD - 1);
                        end else begin
                            // Next bit goes out on the falling edge of sclk.
                            bit_cnt <= bit_cnt - 1'b1;
                            mosi    <= sh[DATA_WIDTH-2];
                            sh      <= {sh[DATA_WIDTH-2:0], 1'b0};
                            cnt     <= CNT_W'(SCLK_DIV - 1);
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cs_n  <= '1;
                        mosi  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if ((LDAC_MODE == 0) || last_q) begin
                        state  <= S_LDAC;
                        ldac_n <= 1'b0;
                        cnt    <= CNT_W'(LDAC_CYC - 1);
                    end else begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        s_axis_ready <= en;
                    end
                end
                S_LDAC: begin
                    if (cnt == '0) begin
                        state        <= S_IDLE;
                        ldac_n       <= 1'b1;
                        busy         <= 1'b0;
                        s_axis_ready <= en;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    sclk         <= 1'b0;
                    mosi         <= 1'b0;
                    cs_n         <= '1;
                    ldac_n       <= 1'b1;
                    busy         <= 1'b0;
                    s_axis_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
